// File: rtl/iir_opti_pkg.sv
// Shared types and default sizes for the opti_top IIR frame scheduler.
package iir_opti_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int ADDR_W_DEF    = 11;
  localparam int N_SAMPLES_DEF = 2048;

  // Sample counters carry one extra bit so a full frame count never wraps.
  localparam int CNT_W = ADDR_W_DEF + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int cnt_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/iir_stab_det.sv
// Output-settling detector: counts consecutive captures whose step from the
// previous captured output is within STAB_THR and flags once STAB_LEN is hit.
module iir_stab_det
  import iir_opti_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int STAB_THR = 4,
  parameter int STAB_LEN = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     cap_i,
  input  logic signed [DATA_W-1:0] y_i,
  output logic                     stable_o
);

  localparam int SW = $clog2(STAB_LEN + 1);
  localparam logic [SW-1:0]     LEN_L = SW'(STAB_LEN);
  localparam logic [DATA_W-1:0] THR_L = DATA_W'(STAB_THR);

  // |v| of a DATA_W+1 bit difference, clipped to the DATA_W bit unsigned range.
  function automatic logic [DATA_W-1:0] abs_sat(input logic signed [DATA_W:0] v);
    logic [DATA_W:0] mag;
    mag = v[DATA_W] ? $unsigned(-v) : $unsigned(v);
    if (mag[DATA_W]) return '1;
    return mag[DATA_W-1:0];
  endfunction

  logic [SW-1:0]            cnt_q, cnt_d;
  logic signed [DATA_W-1:0] y_prev_q, y_prev_d;
  logic                     stable_q, stable_d;
  logic signed [DATA_W:0]   diff;

  assign diff     = (DATA_W+1)'(y_i) - (DATA_W+1)'(y_prev_q);
  assign stable_o = stable_q;

  // Next-state of the run-length counter, previous-output register and flag.
  always_comb begin
    cnt_d    = cnt_q;
    y_prev_d = y_prev_q;
    stable_d = stable_q;
    if (clr_i) begin
      cnt_d    = '0;
      y_prev_d = '0;
      stable_d = 1'b0;
    end else if (cap_i) begin
      if (abs_sat(diff) <= THR_L) begin
        cnt_d = (cnt_q == LEN_L) ? cnt_q : cnt_q + SW'(1);
      end else begin
        cnt_d = '0;
      end
      y_prev_d = y_i;
      stable_d = (cnt_d == LEN_L);
    end
  end

  // Detector state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      y_prev_q <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      y_prev_q <= y_prev_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/iir_frame_sched.sv
// Frame sequencer for the 7-section SOS cascade: admits one frame of input
// samples, drains the cascade, writes addressed outputs and pulses filter_done.
// Optional settling detector is built when IIR_STABLE_DET_EN is defined;
// otherwise stable_out is tied low.
module iir_frame_sched
  import iir_opti_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int DRAIN_TMO = 64,
  parameter int STAB_THR  = 4,
  parameter int STAB_LEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     data_in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] casc_din,
  output logic                     casc_din_valid,
  output logic                     pipeline_en,
  input  logic signed [DATA_W-1:0] casc_dout,
  input  logic                     casc_dout_valid,
  output logic [ADDR_W-1:0]        addr,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     data_out_valid,
  output logic                     filter_done,
  output logic                     busy,
  output logic                     stable_out,
  output logic                     timeout_err
);

  localparam int CW = cnt_width(ADDR_W);
  localparam int WW = $clog2(DRAIN_TMO + 1);
  localparam logic [CW-1:0] N_LIM = CW'(N_SAMPLES);
  localparam logic [WW-1:0] W_LIM = WW'(DRAIN_TMO);

  if (N_SAMPLES < 1 || N_SAMPLES > (1 << ADDR_W) || DRAIN_TMO < 1 ||
      STAB_LEN < 1 || STAB_THR < 0) begin : g_cfg_err
    $error("iir_frame_sched: invalid parameter set");
  end

  state_e                   state_q, state_d;
  logic [CW-1:0]            in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [WW-1:0]            wdog_q, wdog_d;
  logic                     tmo_q, tmo_d;
  logic                     busy_q;
  logic signed [DATA_W-1:0] casc_din_q, data_out_q;
  logic                     casc_din_vld_q, dout_vld_q;
  logic [ADDR_W-1:0]        addr_q;
  logic                     start_frame, active, accept, capture;

  assign start_frame = (state_q == IDLE) && start;
  assign active      = (state_q == RUN) || (state_q == DRAIN);
  assign accept      = data_in_valid && (state_q == RUN);
  assign capture     = casc_dout_valid && active && (out_cnt_q < N_LIM);

  assign in_ready       = (state_q == RUN);
  assign filter_done    = (state_q == DONE);
  assign busy           = busy_q;
  assign pipeline_en    = busy_q;
  assign casc_din       = casc_din_q;
  assign casc_din_valid = casc_din_vld_q;
  assign data_out       = data_out_q;
  assign data_out_valid = dout_vld_q;
  assign addr           = addr_q;
  assign timeout_err    = tmo_q;

  // FSM transitions, frame counters and drain watchdog.
  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    wdog_d    = wdog_q;
    tmo_d     = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          wdog_d    = '0;
          tmo_d     = 1'b0;
        end
      end
      RUN: begin
        if (accept)  in_cnt_d  = in_cnt_q + CW'(1);
        if (capture) out_cnt_d = out_cnt_q + CW'(1);
        if (in_cnt_d == N_LIM) state_d = DRAIN;
      end
      DRAIN: begin
        if (capture) begin
          out_cnt_d = out_cnt_q + CW'(1);
          wdog_d    = '0;
        end else begin
          wdog_d    = wdog_q + WW'(1);
        end
        if (out_cnt_d == N_LIM) begin
          state_d = DONE;
        end else if (wdog_d == W_LIM) begin
          state_d = DONE;
          tmo_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers; reset aborts any frame in flight without filter_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      wdog_q    <= '0;
      tmo_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      wdog_q    <= wdog_d;
      tmo_q     <= tmo_d;
      busy_q    <= (state_d == RUN) || (state_d == DRAIN);
    end
  end

  // Cascade input and addressed output registers, one cycle behind the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      casc_din_q     <= '0;
      casc_din_vld_q <= 1'b0;
      data_out_q     <= '0;
      addr_q         <= '0;
      dout_vld_q     <= 1'b0;
    end else begin
      casc_din_vld_q <= accept;
      if (accept) casc_din_q <= data_in;
      dout_vld_q <= capture;
      if (capture) begin
        data_out_q <= casc_dout;
        addr_q     <= out_cnt_q[ADDR_W-1:0];
      end
    end
  end

`ifdef IIR_STABLE_DET_EN
  iir_stab_det #(
    .DATA_W   (DATA_W),
    .STAB_THR (STAB_THR),
    .STAB_LEN (STAB_LEN)
  ) u_stab_det (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (start_frame),
    .cap_i    (capture),
    .y_i      (casc_dout),
    .stable_o (stable_out)
  );
`else
  assign stable_out = 1'b0;
`endif

endmodule
